// File: rtl/srrc_interp_tx.sv
// ---------------------------------------------------------------------------
// srrc_interp_tx
// Square-root-raised-cosine pulse-shaping interpolator. One symbol is accepted
// per valid/ready handshake, and SPS filtered samples are produced for it. The
// filter is polyphase: output phase p is sum_j hist[j] * coef[p + j*SPS],
// j = 0..L-1, with L = ceil(TAPS/SPS). A single multiplier is shared, so each
// sample takes L clocks and each symbol takes SPS*L clocks.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous reset, active low
//   in_data     signed input symbol (DATA_W)
//   in_valid    in_data valid
//   in_ready    symbol accepted on an edge where in_valid && in_ready
//   coef_we     coefficient write enable (allowed at any time, even in reset)
//   coef_addr   coefficient index; indices >= TAPS are dropped
//   coef_wdata  signed Q1.(COEF_W-1) coefficient
//   out_data    rounded, saturated sample (OUT_W), held between strobes
//   out_valid   one-cycle strobe for out_data
//   sat_flag    sticky: some sample was clamped since the last reset
//   busy        high while the MAC is running
// ---------------------------------------------------------------------------
module srrc_interp_tx #(
   parameter int DATA_W = 11,
   parameter int COEF_W = 16,
   parameter int OUT_W  = 16,
   parameter int TAPS   = 33,
   parameter int SPS    = 4,
   parameter int SHIFT  = 15,
   localparam int AW    = $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     coef_we,
   input  logic [AW-1:0]            coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_valid,
   output logic                     sat_flag,
   output logic                     busy
);

   localparam int L     = (TAPS + SPS - 1) / SPS;
   localparam int JW    = (L > 1) ? $clog2(L) : 1;
   localparam int PW    = (SPS > 1) ? $clog2(SPS) : 1;
   localparam int IW    = $clog2(SPS * L) + 1;
   localparam int ACC_W = DATA_W + COEF_W + $clog2(L) + 1;

   localparam logic [JW-1:0]         LAST_J = JW'(L - 1);
   localparam logic [PW-1:0]         LAST_P = PW'(SPS - 1);
   localparam logic [AW:0]           TAPS_A = (AW + 1)'(TAPS);
   localparam logic [IW-1:0]         TAPS_I = IW'(TAPS);
   localparam logic signed [ACC_W:0] HALF   = (ACC_W + 1)'(2 ** (SHIFT - 1));
   localparam logic signed [ACC_W:0] MAX_V  = (ACC_W + 1)'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W:0] MIN_V  = ~MAX_V;

   typedef enum logic {IDLE, MAC} state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           p_q, p_d;
   logic [JW-1:0]           j_q, j_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    sat_q, sat_d;

   logic signed [DATA_W-1:0] hist_q [L];
   // Small table: kept as distributed RAM so a tap can be read in the same
   // cycle it is multiplied. Power-up content is zero and reset leaves it.
   logic signed [COEF_W-1:0] coef_q [TAPS] = '{default: '0};

   logic                     accept;
   logic [IW-1:0]            tap_idx;
   logic signed [COEF_W-1:0] coef_rd;
   logic signed [DATA_W-1:0] hist_rd;
   logic signed [ACC_W-1:0]  prod, sum;
   logic signed [ACC_W:0]    rnd, shifted;
   logic signed [OUT_W-1:0]  clamped;
   logic                     clip;

   assign accept    = (state_q == IDLE) && in_valid;
   assign in_ready  = (state_q == IDLE) && reset;
   assign busy      = (state_q == MAC);
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign sat_flag  = sat_q;

   // Taps past the end of the prototype read as zero.
   assign tap_idx = IW'(p_q) + IW'(j_q) * IW'(SPS);
   assign coef_rd = (tap_idx < TAPS_I) ? coef_q[tap_idx[AW-1:0]] : '0;
   assign hist_rd = hist_q[j_q];
   assign prod    = ACC_W'(hist_rd) * ACC_W'(coef_rd);
   assign sum     = acc_q + prod;

   // Round half toward +inf, then clamp; one extra bit keeps the +HALF exact.
   assign rnd     = (ACC_W + 1)'(sum) + HALF;
   assign shifted = rnd >>> SHIFT;

   always_comb begin
      clip    = 1'b0;
      clamped = OUT_W'(shifted);
      if (shifted > MAX_V) begin
         clip    = 1'b1;
         clamped = OUT_W'(MAX_V);
      end else if (shifted < MIN_V) begin
         clip    = 1'b1;
         clamped = OUT_W'(MIN_V);
      end
   end

   always_comb begin
      state_d     = state_q;
      p_d         = p_q;
      j_d         = j_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      sat_d       = sat_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = MAC;
               p_d     = '0;
               j_d     = '0;
               acc_d   = '0;
            end
         end
         MAC: begin
            if (j_q == LAST_J) begin
               out_data_d  = clamped;
               out_valid_d = 1'b1;
               sat_d       = sat_q | clip;
               acc_d       = '0;
               j_d         = '0;
               if (p_q != LAST_P) p_d = p_q + 1'b1;
               else               state_d = IDLE;
            end else begin
               acc_d = sum;
               j_d   = j_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         p_q         <= '0;
         j_q         <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         p_q         <= p_d;
         j_q         <= j_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
      end
   end

   // Symbol history: newest symbol enters at index 0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < L; k++) hist_q[k] <= '0;
      end else if (accept) begin
         for (int k = L - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
         hist_q[0] <= in_data;
      end
   end

   // Coefficient port ignores reset so tables can be loaded during it.
   always_ff @(posedge clk) begin
      if (coef_we && ({1'b0, coef_addr} < TAPS_A)) coef_q[coef_addr] <= coef_wdata;
   end

endmodule

// File: tb/tb_srrc_interp_tx.sv
// ---------------------------------------------------------------------------
// tb_srrc_interp_tx
// Scoreboard bench for srrc_interp_tx. Stimulus pushes hand-computed samples
// into per-instance queues; monitors pop and compare on every out_valid.
// Instance A uses default widths, instance B uses OUT_W=12 for saturation.
// ---------------------------------------------------------------------------
module tb_srrc_interp_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic signed [10:0] a_in_data, b_in_data;
   logic               a_in_valid, a_in_ready, b_in_valid, b_in_ready;
   logic               a_coef_we, b_coef_we;
   logic [5:0]         a_coef_addr, b_coef_addr;
   logic signed [15:0] a_coef_wdata, b_coef_wdata;
   logic signed [15:0] a_out_data;
   logic signed [11:0] b_out_data;
   logic               a_out_valid, a_sat, a_busy;
   logic               b_out_valid, b_sat, b_busy;

   srrc_interp_tx dut_a (
      .clk(clk), .reset(reset),
      .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .coef_we(a_coef_we), .coef_addr(a_coef_addr), .coef_wdata(a_coef_wdata),
      .out_data(a_out_data), .out_valid(a_out_valid), .sat_flag(a_sat), .busy(a_busy)
   );

   srrc_interp_tx #(.OUT_W(12)) dut_b (
      .clk(clk), .reset(reset),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_wdata(b_coef_wdata),
      .out_data(b_out_data), .out_valid(b_out_valid), .sat_flag(b_sat), .busy(b_busy)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int exp_a[$];
   int exp_b[$];
   int strobe_a[$];
   int n_strobe_a = 0;
   int busy_ready_viol = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // Monitors
   always @(negedge clk) begin
      int e;
      if (a_busy && a_in_ready) busy_ready_viol++;
      if (a_out_valid) begin
         n_strobe_a++;
         strobe_a.push_back(cyc);
         if (exp_a.size() == 0) check("A unexpected strobe", 1, 0);
         else begin
            e = exp_a.pop_front();
            $display("A cyc %0d out_data=%0d expect=%0d", cyc, a_out_data, e);
            check("A out_data", a_out_data, e);
         end
      end
   end

   always @(negedge clk) begin
      int e;
      if (b_out_valid) begin
         if (exp_b.size() == 0) check("B unexpected strobe", 1, 0);
         else begin
            e = exp_b.pop_front();
            $display("B cyc %0d out_data=%0d expect=%0d sat=%0d", cyc, b_out_data, e, b_sat);
            check("B out_data", b_out_data, e);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_wcoef(input int addr, input int val);
      a_coef_we    = 1'b1;
      a_coef_addr  = addr[5:0];
      a_coef_wdata = val[15:0];
      tick();
      a_coef_we    = 1'b0;
   endtask

   task automatic a_send(input int d, input int e0, input int e1, input int e2,
                         input int e3, input bit push, output int acc_edge);
      int t = 0;
      while (!a_in_ready && t < 200) begin
         tick();
         t++;
      end
      if (!a_in_ready) check("A in_ready timeout", 0, 1);
      a_in_valid = 1'b1;
      a_in_data  = d[10:0];
      if (push) begin
         exp_a.push_back(e0); exp_a.push_back(e1);
         exp_a.push_back(e2); exp_a.push_back(e3);
      end
      tick();
      acc_edge   = cyc;
      a_in_valid = 1'b0;
      $display("A cyc %0d accepted symbol %0d", cyc, d);
   endtask

   task automatic a_drain();
      int t = 0;
      while ((exp_a.size() != 0 || a_busy) && t < 400) begin
         tick();
         t++;
      end
      check("A drain", int'(exp_a.size() == 0 && !a_busy), 1);
   endtask

   initial begin
      int acc;
      int acc3[3];
      int n0;
      int t;
      int d;
      reset = 1'b0;
      a_in_valid = 0; a_in_data = 0; a_coef_we = 0; a_coef_addr = 0; a_coef_wdata = 0;
      b_in_valid = 0; b_in_data = 0; b_coef_we = 0; b_coef_addr = 0; b_coef_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst in_ready", a_in_ready, 0);
      check("rst out_valid", a_out_valid, 0);
      check("rst out_data", a_out_data, 0);
      check("rst busy", a_busy, 0);
      check("rst sat_flag", a_sat, 0);
      reset = 1'b1;
      #1;
      check("release in_ready", a_in_ready, 1);
      tick();

      // Impulse through coef[5]: appears on phase 1 of the following symbol.
      a_wcoef(5, 16384);
      strobe_a.delete();
      a_send(200, 0, 0, 0, 0, 1'b1, acc);
      a_drain();
      check("strobe count sym1", strobe_a.size(), 4);
      if (strobe_a.size() >= 4) begin
         check("first strobe latency", strobe_a[0] - acc, 9);
         for (int i = 1; i < 4; i++) check("strobe spacing", strobe_a[i] - strobe_a[i-1], 9);
      end
      a_send(0, 0, 100, 0, 0, 1'b1, acc);
      a_drain();

      // Rounding of an exact half.
      a_wcoef(5, 0);
      a_wcoef(0, 32);
      a_send(512, 1, 0, 0, 0, 1'b1, acc);
      a_drain();
      a_send(-512, 0, 0, 0, 0, 1'b1, acc);
      a_drain();

      // Back-to-back handshake with in_valid held high.
      n0 = n_strobe_a;
      busy_ready_viol = 0;
      a_in_valid = 1'b1;
      a_in_data  = 11'sd1000;
      for (int k = 0; k < 3; k++) begin
         t = 0;
         while (!a_in_ready && t < 100) begin
            tick();
            t++;
         end
         check("held valid ready", a_in_ready, 1);
         exp_a.push_back(k == 0 ? 1 : (k == 1 ? -1 : 0));
         exp_a.push_back(0); exp_a.push_back(0); exp_a.push_back(0);
         tick();
         acc3[k] = cyc;
         $display("A cyc %0d accepted held symbol %0d", cyc, a_in_data);
         a_in_data = (k == 0) ? -11'sd1000 : 11'sd0;
      end
      a_in_valid = 1'b0;
      a_drain();
      check("accept period 1", acc3[1] - acc3[0], 37);
      check("accept period 2", acc3[2] - acc3[1], 37);
      check("strobes for 3 symbols", n_strobe_a - n0, 12);
      check("in_ready during MAC", busy_ready_viol, 0);

      // Saturation on the 12-bit instance.
      for (int k = 0; k < 33; k++) begin
         b_coef_we = 1'b1; b_coef_addr = 6'(k); b_coef_wdata = 16'sd32767;
         tick();
      end
      b_coef_we = 1'b0;
      check("B sat before", b_sat, 0);
      b_in_valid = 1'b1;
      b_in_data  = 11'sd1023;
      for (int k = 1; k <= 10; k++) begin
         t = 0;
         while (!b_in_ready && t < 100) begin
            tick();
            t++;
         end
         check("B ready", b_in_ready, 1);
         d = (k == 1) ? 1023 : ((k == 2) ? 2046 : 2047);
         for (int p = 0; p < 4; p++) exp_b.push_back(d);
         tick();
         $display("B cyc %0d accepted symbol 1023 (#%0d)", cyc, k);
      end
      b_in_valid = 1'b0;
      t = 0;
      while ((exp_b.size() != 0 || b_busy) && t < 600) begin
         tick();
         t++;
      end
      check("B drain", int'(exp_b.size() == 0 && !b_busy), 1);
      check("B sat after", b_sat, 1);
      repeat (20) tick();
      check("B sat sticky", b_sat, 1);

      // Reset mid-MAC; a coefficient write during reset still lands.
      a_wcoef(0, 64);
      a_wcoef(1, 128);
      a_wcoef(2, 192);
      a_wcoef(3, -128);
      a_send(512, 1, 2, 3, -2, 1'b1, acc);
      a_drain();
      check("out_data held", a_out_data, -2);
      a_send(512, 0, 0, 0, 0, 1'b0, acc);
      repeat (5) tick();
      check("busy before reset", a_busy, 1);
      reset = 1'b0;
      a_coef_we = 1'b1; a_coef_addr = 6'd3; a_coef_wdata = -16'sd256;
      tick();
      a_coef_we = 1'b0;
      tick();
      check("mid rst in_ready", a_in_ready, 0);
      check("mid rst out_valid", a_out_valid, 0);
      check("mid rst out_data", a_out_data, 0);
      check("mid rst busy", a_busy, 0);
      check("mid rst B sat", b_sat, 0);
      reset = 1'b1;
      #1;
      check("post rst in_ready", a_in_ready, 1);
      tick();
      a_send(512, 1, 2, 3, -4, 1'b1, acc);
      a_drain();

      // Coefficient write during phase 2, then an out-of-range write.
      a_send(512, 1, 2, 3, -4, 1'b1, acc);
      repeat (20) tick();
      check("busy at phase 2 write", a_busy, 1);
      a_wcoef(0, 16384);
      a_drain();
      a_send(100, 50, 0, 1, -1, 1'b1, acc);
      a_drain();
      a_wcoef(40, 12345);
      a_send(100, 50, 0, 1, -1, 1'b1, acc);
      a_drain();
      check("A final sat", a_sat, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/srrc_interp_tx.md
Name: srrc_interp_tx

Overview:
Parametrised square-root-raised-cosine pulse-shaping interpolator, the next-generation transmit filter. It accepts one symbol per valid/ready handshake and emits SPS filtered output samples per symbol. It uses a polyphase, time-multiplexed MAC: one multiply per clock. Coefficients are run-time loadable, and the output is rounded, saturated and flagged on overflow.

Parameters:
DATA_W, 11, input symbol width (signed)
COEF_W, 16, coefficient width (signed, Q1.(COEF_W-1))
OUT_W, 16, output sample width (signed)
TAPS, 33, prototype filter length
SPS, 4, samples per symbol (interpolation factor), >=1
SHIFT, 15, right-shift applied to the accumulator before saturation, >=1

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (0 = reset)
in_data  in  DATA_W  signed input symbol
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a symbol this cycle
coef_we  in  1  coefficient write enable
coef_addr  in  $clog2(TAPS)  coefficient index
coef_wdata  in  COEF_W  signed coefficient value
out_data  out  OUT_W  signed filtered sample
out_valid  out  1  one-cycle strobe; out_data valid
sat_flag  out  1  sticky; set when any output saturated
busy  out  1  high in MAC state

Behaviour:
- Constants: L = ceil(TAPS/SPS). coef[k] for k>=TAPS reads as 0. hist[0..L-1] is the symbol history; hist[0] is the newest symbol.
- Output definition: output sample for phase p = sum over j=0..L-1 of hist[j]*coef[p+j*SPS]. This equals zero-stuffing by SPS followed by the TAPS FIR.
- Accumulator width: DATA_W+COEF_W+$clog2(L)+1. Products are full-precision signed.
- Rounding and saturation:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift; exact half rounds toward +inf).
  - Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If clamping occurs, set sat_flag; it stays set until reset.
- FSM states: IDLE, MAC.
  - IDLE: in_ready=1, busy=0. On in_valid&&in_ready at an edge: hist shifts (hist[j]<=hist[j-1], hist[0]<=in_data), p<=0, j<=0, acc<=0, go to MAC.
  - MAC: in_ready=0, busy=1. One tap is accumulated per edge, j=0..L-1.
  - At the edge with j=L-1: out_data is registered from the final sum, out_valid<=1 for exactly one cycle, acc<=0, j<=0.
  - If p<SPS-1 at that edge: p<=p+1 and stay in MAC.
  - Otherwise go to IDLE.
- Timing:
  - First output strobe is L cycles after the accept edge.
  - Later outputs follow every L cycles.
  - in_ready returns 1 in the cycle after the last strobe's edge.
  - Minimum symbol period is SPS*L+1 cycles. There is no output backpressure.
- in_valid while in_ready=0 is ignored; the symbol is not consumed.
- Coefficient writes:
  - Legal in any state. The write takes effect at the edge, and reads from the next cycle see the new value.
  - coef_addr>=TAPS is ignored.
  - Coefficient memory is not cleared by reset; its initial content is 0.
- Reset (reset=0 at an edge), including mid-MAC:
  - State->IDLE; hist, acc, p, j cleared.
  - out_data=0, out_valid=0, sat_flag=0, busy=0.
  - in_ready=0 while reset is held, and 1 in the first cycle after release.
  - Any partial output is discarded; no strobe is emitted.
- A coefficient write during a cycle in which reset=0 is still performed.

Test Plan:
- Defaults; all coef=0 except coef[5]=16384; send 200 then 0 -> first symbol outputs 0,0,0,0; second symbol outputs 0,100,0,0. Strobes 9 cycles apart, first strobe 9 cycles after accept.
- coef[0]=32; send 512 -> phase-0 output 1 (half rounds up). Send -512 -> phase-0 output 0.
- OUT_W=12; all 33 coef=32767; hold in_valid=1 with in_data=1023 for 10 symbols -> outputs clamp at 2047 and sat_flag=1. sat_flag stays 1 until reset, then returns 0.
- Handshake: in_valid held high continuously -> accepts exactly every 37 cycles. in_ready is 0 throughout MAC. Exactly 4 strobes per symbol; no symbol dropped or duplicated.
- Reset pulsed 5 cycles into MAC -> no strobe; out_data=0; in_ready=1 one cycle after release. Coefficients are retained: the next impulse reproduces the coef values.
- Write coef[0]=16384 while busy in phase 2, then send symbol 100 -> the following symbol's phase-0 output reflects the new coefficient (50). Write to coef_addr=40 -> no effect on any output.
